smvm_stream_tx: RTL and testbench
=================================

Name: smvm_stream_tx

Overview:
Transmitter for the SMVM input stream. It takes a frame configuration, a dense vector and dense matrix rows from a host. It emits the serial symbol stream (val/col/ipv) consumed by the SMVM engine: rows header, cols header, vector elements, then (value, index) pairs for every nonzero, then a terminator. It sits between the host/loader and the SMVM core and performs the dense-to-sparse compression on the fly.

Parameters:
MAX_COLS, 7, maximum matrix columns / vector length (col index fits 3 bits; legal cols 1..MAX_COLS)
FIFO_DEPTH, 2, row buffer depth in rows

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse, honoured only in IDLE
rows_cfg  in  8  row count, 1..255, sampled on start
cols_cfg  in  3  column count, 1..MAX_COLS, sampled on start
vec_flat  in  8*MAX_COLS  signed vector, element i at [8i+7:8i], sampled on start
row_valid  in  1  host row available
row_ready  out  1  row accepted when row_valid&row_ready
row_data  in  8*MAX_COLS  dense signed row, element i at [8i+7:8i]; elements >= cols ignored
val_out  out  8  stream value
col_out  out  3  stream column field
ipv_out  out  1  last-nonzero-of-row flag
out_valid  out  1  symbol valid (bench/monitor qualifier)
busy  out  1  frame in progress
done  out  1  one-cycle pulse after terminator
err_empty_row  out  1  sticky, cleared on accepted start
err_underrun  out  1  sticky, cleared on accepted start

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0. Reset mid-frame aborts immediately; no terminator is sent.
- All stream outputs are registered. Start accepted at edge t gives HDR_R symbol valid in cycle t+1. Symbols are contiguous, one per cycle, with no bubbles from HDR_R through TERM.
- States: IDLE -> HDR_R -> HDR_C -> VEC -> (VAL <-> IDX)* -> TERM -> DRAIN (if rows remain unaccepted) -> IDLE.
- HDR_R: val=rows, col=0, ipv=0.
- HDR_C: val=0, col=cols, ipv=0.
- VEC: cols cycles, val=vec[i] for i=0..cols-1, col=0, ipv=0.
- Row handling: the head row is popped into a working register with nz mask = (elem!=0) over cols. The lowest set bit is selected.
- VAL: val=elem[sel], col=0, ipv=1 iff sel is the only remaining mask bit.
- IDX: val=0, col=sel, ipv=0. Clears the mask bit.
- Row boundary: the next row is popped in the last VAL/IDX cycle of the previous row (or the last VEC cycle for row 0). This keeps VAL contiguous.
- TERM: val=0, col=0, ipv=0, out_valid=1. It is entered after the last IDX of row rows-1, or on abort. done pulses in the following cycle; busy drops with done.
- Abort (pop needed but FIFO empty): set err_underrun, go to TERM instead of VAL.
- Abort (popped row has zero mask): set err_empty_row, go to TERM. The empty row counts as consumed.
- Error priority: underrun is checked before empty-row.
- row_ready = busy & ~fifo_full & (rows_accepted < rows). rows_accepted counts from start. Rows arriving during HDR/VEC are buffered.
- DRAIN: after an aborted TERM, keep row_ready high and discard rows until rows_accepted == rows. done is still issued after TERM; busy stays high until the drain completes.
- start during busy is ignored. Config must be legal: cols=0 or cols>MAX_COLS is undefined and flagged by a bench assertion only.
- Widths: val is 8-bit two's complement pass-through, with no arithmetic. Row counter 8-bit; column counter 3-bit. No wrap: the counters stop at cols-1 and rows-1.

Decomposition:
- Shared package smvm_pkg holds:
  - the state enum (IDLE, HDR_R, HDR_C, VEC, VAL, IDX, TERM, DRAIN);
  - MAX_COLS and the field widths (VAL_W=8, COL_W=3, ROWS_W=8).
- One sub-module, smvm_row_fifo: synchronous FIFO of FIFO_DEPTH x 8*MAX_COLS, with push/pop/full/empty and the async reset.
- The lowest-set-bit picker stays inline as a function.

Test Plan:
- Nominal frame: rows=2, cols=3, vec=[1,2,3], rows [5,0,7] and [0,-1,0] with row_valid held high.
  - Expected symbols (val/col/ipv): 2/0/0, 0/3/0, 1,2,3, 5/0/0, 0/0/0, 7/0/1, 0/2/0, FF/0/1, 0/1/0, 0/0/0 (TERM).
  - 12 contiguous out_valid cycles, done on cycle 13, no errors.
- Full row: rows=1, cols=7, row=[1..7]. Expect 7 VAL/IDX pairs with col 0..6, ipv=1 only on the val=7 entry, then TERM.
- Empty row: rows=3, row1 all-zero.
  - Row0 pairs, then TERM, err_empty_row=1.
  - Row2 still accepted (drained); busy drops after row2 handshake.
- Underrun: rows=1, row_valid low throughout. After the 3 VEC symbols, TERM follows immediately, err_underrun=1, done pulses; busy holds until the row arrives.
- Control: start pulsed mid-frame is ignored and the stream is unchanged. Back-to-back frames clear errors on the second start. rst_n low during VEC forces all outputs to 0 asynchronously; the FIFO is empty afterwards.

Source files
------------

// File: rtl/smvm_pkg.sv
// Shared types and field widths for the SMVM stream transmitter.
package smvm_pkg;
    localparam int MAX_COLS = 7;
    localparam int VAL_W    = 8;
    localparam int COL_W    = 3;
    localparam int ROWS_W   = 8;
    localparam int ROW_W    = VAL_W * MAX_COLS;

    typedef enum logic [2:0] {
        IDLE,
        HDR_R,
        HDR_C,
        VEC,
        VAL,
        IDX,
        TERM,
        DRAIN
    } smvm_state_e;
endpackage

// File: rtl/smvm_stream_tx_if.sv
// Host row handshake plus outgoing symbol stream of the SMVM transmitter.
interface smvm_stream_tx_if;
    import smvm_pkg::*;

    logic             row_valid;
    logic             row_ready;
    logic [ROW_W-1:0] row_data;
    logic [VAL_W-1:0] val_out;
    logic [COL_W-1:0] col_out;
    logic             ipv_out;
    logic             out_valid;

    modport master (
        input  row_valid, row_data,
        output row_ready, val_out, col_out, ipv_out, out_valid
    );

    modport slave (
        output row_valid, row_data,
        input  row_ready, val_out, col_out, ipv_out, out_valid
    );
endinterface

// File: rtl/smvm_row_fifo.sv
// Small synchronous row buffer with show-ahead read; flush discards all entries.
module smvm_row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_do_push = push & ~full & ~flush;
    assign w_do_pop  = pop & ~empty & ~flush;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/smvm_stream_tx.sv
// Dense-to-sparse SMVM stream transmitter: headers, vector, (value,index) pairs, terminator.
module smvm_stream_tx
    import smvm_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROWS_W-1:0] rows_cfg,
    input  logic [COL_W-1:0]  cols_cfg,
    input  logic [ROW_W-1:0]  vec_flat,
    smvm_stream_tx_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              err_empty_row,
    output logic              err_underrun
);
    smvm_state_e       r_state;
    logic [ROWS_W-1:0] r_rows;
    logic [ROWS_W-1:0] r_acc;
    logic [ROWS_W-1:0] r_pop_cnt;
    logic [COL_W-1:0]  r_cols;
    logic [COL_W-1:0]  r_vidx;
    logic [ROW_W-1:0]  r_vec;
    logic [ROW_W-1:0]  r_work;
    logic [MAX_COLS-1:0] r_mask;
    logic [COL_W-1:0]  r_sel;
    logic [VAL_W-1:0]  r_val;
    logic [COL_W-1:0]  r_col;
    logic              r_ipv;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err_empty;
    logic              r_err_under;

    logic [ROW_W-1:0]    w_head;
    logic [MAX_COLS-1:0] w_head_mask;
    logic [COL_W-1:0]    w_head_sel;
    logic [MAX_COLS-1:0] w_rem;
    logic [COL_W-1:0]    w_rem_sel;
    logic [COL_W-1:0]    w_vidx_inc;
    logic w_fifo_full, w_fifo_empty;
    logic w_row_ready, w_push, w_pop, w_flush;
    logic w_last_vec, w_need_row, w_acc_done;

    function automatic logic [COL_W-1:0] lowest_idx(input logic [MAX_COLS-1:0] m);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = MAX_COLS - 1; i >= 0; i--) begin
            if (m[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [MAX_COLS-1:0] m);
        return (m & (m - MAX_COLS'(1))) == '0;
    endfunction

    // Only the first cols elements of a row can contribute nonzeros.
    for (genvar gi = 0; gi < MAX_COLS; gi++) begin : g_mask
        assign w_head_mask[gi] = (w_head[VAL_W*gi +: VAL_W] != '0) && (COL_W'(gi) < r_cols);
    end

    assign w_head_sel  = lowest_idx(w_head_mask);
    assign w_rem       = r_mask & ~(MAX_COLS'(1) << r_sel);
    assign w_rem_sel   = lowest_idx(w_rem);
    assign w_vidx_inc  = r_vidx + COL_W'(1);
    assign w_last_vec  = (r_vidx == r_cols - COL_W'(1));
    assign w_need_row  = ((r_state == VEC) && w_last_vec) || ((r_state == IDX) && (w_rem == '0));
    assign w_pop       = w_need_row && (r_pop_cnt != r_rows) && !w_fifo_empty;
    assign w_row_ready = r_busy && !w_fifo_full && (r_acc < r_rows);
    assign w_push      = bus.row_valid && w_row_ready;
    // Anything still buffered after the terminator belongs to an aborted frame.
    assign w_flush     = (r_state == TERM) || (r_state == DRAIN);
    assign w_acc_done  = (r_acc == r_rows) || (w_push && (r_acc + ROWS_W'(1) == r_rows));

    smvm_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ROW_W)
    ) u_row_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (bus.row_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rows      <= '0;
            r_acc       <= '0;
            r_pop_cnt   <= '0;
            r_cols      <= '0;
            r_vidx      <= '0;
            r_vec       <= '0;
            r_work      <= '0;
            r_mask      <= '0;
            r_sel       <= '0;
            r_val       <= '0;
            r_col       <= '0;
            r_ipv       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_empty <= 1'b0;
            r_err_under <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_val       <= '0;
            r_col       <= '0;
            r_ipv       <= 1'b0;
            r_out_valid <= 1'b0;
            if (w_push) r_acc     <= r_acc + ROWS_W'(1);
            if (w_pop)  r_pop_cnt <= r_pop_cnt + ROWS_W'(1);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rows      <= rows_cfg;
                        r_cols      <= cols_cfg;
                        r_vec       <= vec_flat;
                        r_acc       <= '0;
                        r_pop_cnt   <= '0;
                        r_vidx      <= '0;
                        r_err_empty <= 1'b0;
                        r_err_under <= 1'b0;
                        r_busy      <= 1'b1;
                        r_val       <= rows_cfg;
                        r_out_valid <= 1'b1;
                        r_state     <= HDR_R;
                    end
                end
                HDR_R: begin
                    r_col       <= r_cols;
                    r_out_valid <= 1'b1;
                    r_state     <= HDR_C;
                end
                HDR_C: begin
                    r_vidx      <= '0;
                    r_val       <= r_vec[VAL_W-1:0];
                    r_out_valid <= 1'b1;
                    r_state     <= VEC;
                end
                VEC, IDX: begin
                    r_out_valid <= 1'b1;
                    if (w_need_row) begin
                        // Fetching the next row here keeps VAL back-to-back with the previous symbol.
                        if (w_pop) begin
                            if (w_head_mask == '0) begin
                                r_err_empty <= 1'b1;
                                r_state     <= TERM;
                            end else begin
                                r_work  <= w_head;
                                r_mask  <= w_head_mask;
                                r_sel   <= w_head_sel;
                                r_val   <= w_head[VAL_W*w_head_sel +: VAL_W];
                                r_ipv   <= is_single(w_head_mask);
                                r_state <= VAL;
                            end
                        end else begin
                            if (r_pop_cnt != r_rows) r_err_under <= 1'b1;
                            r_state <= TERM;
                        end
                    end else if (r_state == VEC) begin
                        r_vidx <= w_vidx_inc;
                        r_val  <= r_vec[VAL_W*w_vidx_inc +: VAL_W];
                    end else begin
                        r_mask  <= w_rem;
                        r_sel   <= w_rem_sel;
                        r_val   <= r_work[VAL_W*w_rem_sel +: VAL_W];
                        r_ipv   <= is_single(w_rem);
                        r_state <= VAL;
                    end
                end
                VAL: begin
                    r_col       <= r_sel;
                    r_out_valid <= 1'b1;
                    r_state     <= IDX;
                end
                TERM: begin
                    r_done <= 1'b1;
                    if (w_acc_done) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_acc_done) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.row_ready = w_row_ready;
    assign bus.val_out   = r_val;
    assign bus.col_out   = r_col;
    assign bus.ipv_out   = r_ipv;
    assign bus.out_valid = r_out_valid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_empty_row = r_err_empty;
    assign err_underrun  = r_err_under;
endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed bench for smvm_stream_tx: symbol-by-symbol comparison against hand-written tables.
module tb_smvm_stream_tx;
    import smvm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ROWS_W-1:0] rows_cfg = '0;
    logic [COL_W-1:0]  cols_cfg = '0;
    logic [ROW_W-1:0]  vec_flat = '0;
    logic              busy, done, err_empty_row, err_underrun;

    smvm_stream_tx_if bus ();

    smvm_stream_tx #(.FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rows_cfg      (rows_cfg),
        .cols_cfg      (cols_cfg),
        .vec_flat      (vec_flat),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err_empty_row (err_empty_row),
        .err_underrun  (err_underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = -1;
    logic [11:0] sym_q[$];
    int          cyc_q[$];
    logic [11:0] exp_q[$];
    bit          host_en = 1'b0;
    logic [ROW_W-1:0] host_q[$];

    // Symbol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.out_valid) begin
            sym_q.push_back({bus.val_out, bus.col_out, bus.ipv_out});
            cyc_q.push_back(cyc);
        end
        if (done) done_cyc = cyc;
    end

    // Host: a row is handed over at the next rising edge when ready is seen here.
    always @(negedge clk) begin
        if (host_en && host_q.size() > 0) begin
            bus.row_valid = 1'b1;
            bus.row_data  = host_q[0];
            if (bus.row_ready) void'(host_q.pop_front());
        end else begin
            bus.row_valid = 1'b0;
            bus.row_data  = '0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && start && !busy) begin
            assert (cols_cfg != 3'd0 && rows_cfg != 8'd0)
                else $error("illegal frame config rows=%0d cols=%0d", rows_cfg, cols_cfg);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void add(input logic [7:0] v, input logic [2:0] c, input logic p);
        exp_q.push_back({v, c, p});
    endfunction

    function automatic logic [ROW_W-1:0] pack(input logic [7:0] e0, e1, e2, e3, e4, e5, e6);
        return {e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic start_frame(input logic [7:0] r, input logic [2:0] c, input logic [ROW_W-1:0] v);
        @(negedge clk);
        sym_q.delete();
        cyc_q.delete();
        exp_q.delete();
        done_cyc = -1;
        rows_cfg = r;
        cols_cfg = c;
        vec_flat = v;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " busy cleared"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        int n = sym_q.size();
        check({tag, " symbol count"}, n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++) begin
            $display("%s sym %0d: val=%02h col=%0d ipv=%0b", tag, k, sym_q[k][11:4], sym_q[k][3:1], sym_q[k][0]);
            check($sformatf("%s sym%0d", tag, k), 32'(sym_q[k]), 32'(exp_q[k]));
        end
        if (n > 0) begin
            check({tag, " contiguous"}, cyc_q[n-1] - cyc_q[0], n - 1);
            check({tag, " done slot"}, done_cyc - cyc_q[0], n);
        end
    endtask

    task automatic add_nominal();
        add(8'd2, 3'd0, 1'b0); add(8'd0, 3'd3, 1'b0);
        add(8'd1, 3'd0, 1'b0); add(8'd2, 3'd0, 1'b0); add(8'd3, 3'd0, 1'b0);
        add(8'd5, 3'd0, 1'b0); add(8'd0, 3'd0, 1'b0);
        add(8'd7, 3'd0, 1'b1); add(8'd0, 3'd2, 1'b0);
        add(8'hFF, 3'd0, 1'b1); add(8'd0, 3'd1, 1'b0);
        add(8'd0, 3'd0, 1'b0);
    endtask

    initial begin
        host_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset row_ready", 32'(bus.row_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset errors", 32'({err_empty_row, err_underrun}), 32'd0);
        rst_n = 1'b1;

        // Nominal two-row frame
        host_q.push_back(pack(8'd5, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0));
        host_q.push_back(pack(8'd0, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        start_frame(8'd2, 3'd3, pack(8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0));
        check("t1 hdr valid", 32'(bus.out_valid), 32'd1);
        check("t1 hdr rows", 32'(bus.val_out), 32'd2);
        add_nominal();
        wait_idle("t1", 100);
        check_frame("t1");
        check("t1 errors", 32'({err_empty_row, err_underrun}), 32'd0);
        check("t1 rows taken", host_q.size(), 0);

        // Full row of seven nonzeros
        host_q.push_back(pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7));
        start_frame(8'd1, 3'd7, pack(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16));
        add(8'd1, 3'd0, 1'b0); add(8'd0, 3'd7, 1'b0);
        for (int k = 0; k < 7; k++) add(8'(8'h10 + k), 3'd0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            add(8'(k), 3'd0, k == 7);
            add(8'd0, 3'(k - 1), 1'b0);
        end
        add(8'd0, 3'd0, 1'b0);
        wait_idle("t2", 100);
        check_frame("t2");
        check("t2 errors", 32'({err_empty_row, err_underrun}), 32'd0);

        // Empty middle row; junk beyond cols must be ignored
        host_q.push_back(pack(8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        host_q.push_back(pack(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h55, 8'd0));
        host_q.push_back(pack(8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0));
        start_frame(8'd3, 3'd3, pack(8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0));
        add(8'd3, 3'd0, 1'b0); add(8'd0, 3'd3, 1'b0);
        add(8'd4, 3'd0, 1'b0); add(8'd5, 3'd0, 1'b0); add(8'd6, 3'd0, 1'b0);
        add(8'd2, 3'd0, 1'b1); add(8'd0, 3'd1, 1'b0);
        add(8'd0, 3'd0, 1'b0);
        wait_idle("t3", 100);
        check_frame("t3");
        check("t3 err_empty_row", 32'(err_empty_row), 32'd1);
        check("t3 err_underrun", 32'(err_underrun), 32'd0);
        check("t3 rows drained", host_q.size(), 0);

        // Underrun: no rows offered until well after the terminator
        host_en = 1'b0;
        start_frame(8'd1, 3'd3, pack(8'd7, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0));
        check("t4 empty err cleared", 32'(err_empty_row), 32'd0);
        add(8'd1, 3'd0, 1'b0); add(8'd0, 3'd3, 1'b0);
        add(8'd7, 3'd0, 1'b0); add(8'd8, 3'd0, 1'b0); add(8'd9, 3'd0, 1'b0);
        add(8'd0, 3'd0, 1'b0);
        repeat (12) @(negedge clk);
        check("t4 busy held", 32'(busy), 32'd1);
        check("t4 err_underrun", 32'(err_underrun), 32'd1);
        check_frame("t4");
        host_q.push_back(pack(8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0));
        host_en = 1'b1;
        wait_idle("t4 drain", 40);
        check("t4 row drained", host_q.size(), 0);
        check("t4 err sticky", 32'(err_underrun), 32'd1);

        // Back-to-back frame with a stray start pulse mid-frame
        host_q.push_back(pack(8'd5, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0));
        host_q.push_back(pack(8'd0, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        start_frame(8'd2, 3'd3, pack(8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0));
        check("t5 underrun cleared", 32'(err_underrun), 32'd0);
        add_nominal();
        repeat (3) @(negedge clk);
        rows_cfg = 8'd9;
        cols_cfg = 3'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t5", 100);
        check_frame("t5");

        // Asynchronous reset in the middle of the vector phase
        host_q.push_back(pack(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7));
        start_frame(8'd1, 3'd7, pack(8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37));
        repeat (3) @(negedge clk);
        check("t6 in vec", 32'(bus.val_out), 32'h32);
        rst_n = 1'b0;
        #1;
        check("t6 rst out_valid", 32'(bus.out_valid), 32'd0);
        check("t6 rst stream", 32'({bus.val_out, bus.col_out, bus.ipv_out}), 32'd0);
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst row_ready", 32'(bus.row_ready), 32'd0);
        check("t6 rst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6 row taken before reset", host_q.size(), 0);

        // The buffered row must be gone: this frame has to underrun
        start_frame(8'd1, 3'd2, pack(8'h21, 8'h22, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        add(8'd1, 3'd0, 1'b0); add(8'd0, 3'd2, 1'b0);
        add(8'h21, 3'd0, 1'b0); add(8'h22, 3'd0, 1'b0);
        add(8'd0, 3'd0, 1'b0);
        repeat (8) @(negedge clk);
        check("t7 err_underrun", 32'(err_underrun), 32'd1);
        check_frame("t7");
        host_q.push_back(pack(8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        wait_idle("t7 drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
